// File: rtl/trip_scheduler_pkg.sv
// Shared floor labels, state encoding and call-vector type for the trip scheduler.
package trip_scheduler_pkg;

  localparam int unsigned NUM_FLOORS = 3;
  localparam int unsigned FLOOR_W    = 2;
  localparam int unsigned DWELL_W    = 4;

  localparam logic [FLOOR_W-1:0] FLOOR_F1 = 2'b00;
  localparam logic [FLOOR_W-1:0] FLOOR_F2 = 2'b01;
  localparam logic [FLOOR_W-1:0] FLOOR_F3 = 2'b10;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVING    = 2'd1,
    DOOR_OPEN = 2'd2
  } state_e;

  typedef logic [NUM_FLOORS-1:0] call_vec_t;

endpackage

// File: rtl/trip_scheduler_scan.sv
// scan_select: combinational SCAN goal picker; nearest call in the sweep
// direction, reversing only when nothing is left ahead.
module scan_select
  import trip_scheduler_pkg::*;
#(
  parameter logic [FLOOR_W-1:0] LABEL_F1 = FLOOR_F1,
  parameter logic [FLOOR_W-1:0] LABEL_F2 = FLOOR_F2,
  parameter logic [FLOOR_W-1:0] LABEL_F3 = FLOOR_F3
) (
  input  call_vec_t          call_req,
  input  logic [FLOOR_W-1:0] cur_floor,
  input  logic               dir_up,
  output logic [FLOOR_W-1:0] next_goal_c,
  output logic               next_dir_c,
  output logic               goal_found_c
);

  call_vec_t          above;
  call_vec_t          below;
  logic [FLOOR_W-1:0] near_above;
  logic [FLOOR_W-1:0] near_below;

  // Split pending calls into those above and below the car.
  always_comb begin
    above = '0;
    below = '0;
    if (cur_floor == LABEL_F1) begin
      above = call_req & 3'b110;
    end else if (cur_floor == LABEL_F2) begin
      above = call_req & 3'b100;
      below = call_req & 3'b001;
    end else if (cur_floor == LABEL_F3) begin
      below = call_req & 3'b011;
    end
  end

  assign near_above = above[1] ? LABEL_F2 : LABEL_F3;
  assign near_below = below[1] ? LABEL_F2 : LABEL_F1;

  always_comb begin
    next_goal_c  = cur_floor;
    next_dir_c   = dir_up;
    goal_found_c = 1'b0;
    if (dir_up) begin
      if (|above) begin
        goal_found_c = 1'b1;
        next_goal_c  = near_above;
      end else if (|below) begin
        goal_found_c = 1'b1;
        next_goal_c  = near_below;
        next_dir_c   = 1'b0;
      end
    end else begin
      if (|below) begin
        goal_found_c = 1'b1;
        next_goal_c  = near_below;
      end else if (|above) begin
        goal_found_c = 1'b1;
        next_goal_c  = near_above;
        next_dir_c   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/trip_scheduler.sv
// Three-floor elevator trip scheduler: SCAN dispatch, door dwell, overload hold.
// Optional emergency recall to F1 is built when SOS_RECALL_EN is defined.
module trip_scheduler
  import trip_scheduler_pkg::*;
#(
  parameter int unsigned        DWELL    = 2,
  parameter logic [FLOOR_W-1:0] LABEL_F1 = FLOOR_F1,
  parameter logic [FLOOR_W-1:0] LABEL_F2 = FLOOR_F2,
  parameter logic [FLOOR_W-1:0] LABEL_F3 = FLOOR_F3
) (
  input  logic               door_clk,
  input  logic               button_reset,
  input  call_vec_t          call_req,
  input  logic [FLOOR_W-1:0] cur_floor,
  input  logic               weight_over,
  input  logic               sos_mode,
  output logic [FLOOR_W-1:0] goal_floor,
  output logic               goal_valid,
  output call_vec_t          call_clear,
  output logic               door_open,
  output logic               dir_up
);

  localparam logic [DWELL_W-1:0] DWELL_LOAD = DWELL_W'(DWELL - 1);

  state_e             state, state_nx;
  logic [FLOOR_W-1:0] goal_nx;
  logic               valid_nx, door_nx, dir_nx;
  call_vec_t          clear_nx;
  logic [DWELL_W-1:0] dwell, dwell_nx;

  call_vec_t          pending, cur_bit, goal_bit;
  logic               floor_ok;
  logic [FLOOR_W-1:0] scan_goal_c;
  logic               scan_dir_c, scan_found_c;
  logic               sos;

`ifdef SOS_RECALL_EN
  assign sos = sos_mode;
`else
  logic sos_unused;
  assign sos        = 1'b0;
  assign sos_unused = sos_mode;
`endif

  function automatic call_vec_t floor_bit(input logic [FLOOR_W-1:0] f);
    floor_bit = '0;
    if (f == LABEL_F1)      floor_bit = 3'b001;
    else if (f == LABEL_F2) floor_bit = 3'b010;
    else if (f == LABEL_F3) floor_bit = 3'b100;
  endfunction

  // A call being cleared this cycle is still visible until the latch drops it.
  assign pending  = call_req & ~call_clear;
  assign cur_bit  = floor_bit(cur_floor);
  assign goal_bit = floor_bit(goal_floor);
  assign floor_ok = |cur_bit;

  scan_select #(
    .LABEL_F1(LABEL_F1),
    .LABEL_F2(LABEL_F2),
    .LABEL_F3(LABEL_F3)
  ) u_scan (
    .call_req    (pending),
    .cur_floor   (cur_floor),
    .dir_up      (dir_up),
    .next_goal_c (scan_goal_c),
    .next_dir_c  (scan_dir_c),
    .goal_found_c(scan_found_c)
  );

  always_ff @(posedge door_clk or posedge button_reset) begin
    if (button_reset) begin
      state      <= IDLE;
      goal_floor <= LABEL_F1;
      goal_valid <= 1'b0;
      call_clear <= '0;
      door_open  <= 1'b0;
      dir_up     <= 1'b1;
      dwell      <= '0;
    end else begin
      state      <= state_nx;
      goal_floor <= goal_nx;
      goal_valid <= valid_nx;
      call_clear <= clear_nx;
      door_open  <= door_nx;
      dir_up     <= dir_nx;
      dwell      <= dwell_nx;
    end
  end

  always_comb begin
    state_nx = state;
    goal_nx  = goal_floor;
    valid_nx = goal_valid;
    clear_nx = '0;
    door_nx  = door_open;
    dir_nx   = dir_up;
    dwell_nx = dwell;
    if (!floor_ok) begin
      state_nx = IDLE;
      valid_nx = 1'b0;
      door_nx  = 1'b0;
      dwell_nx = '0;
    end else begin
      case (state)
        IDLE: begin
          if (sos) begin
            if (cur_bit[0]) begin
              state_nx = DOOR_OPEN;
              door_nx  = 1'b1;
              dwell_nx = DWELL_LOAD;
            end else begin
              state_nx = MOVING;
              goal_nx  = LABEL_F1;
              valid_nx = 1'b1;
              dir_nx   = 1'b0;
            end
          end else if (|(pending & cur_bit)) begin
            state_nx = DOOR_OPEN;
            clear_nx = cur_bit;
            door_nx  = 1'b1;
            dwell_nx = DWELL_LOAD;
          end else if (scan_found_c) begin
            state_nx = MOVING;
            goal_nx  = scan_goal_c;
            valid_nx = 1'b1;
            dir_nx   = scan_dir_c;
          end
        end
        MOVING: begin
          if (sos && goal_floor != LABEL_F1) begin
            goal_nx = LABEL_F1;
            dir_nx  = 1'b0;
          end else if (cur_floor == goal_floor) begin
            state_nx = DOOR_OPEN;
            valid_nx = 1'b0;
            clear_nx = sos ? '0 : goal_bit;
            door_nx  = 1'b1;
            dwell_nx = DWELL_LOAD;
          end
        end
        DOOR_OPEN: begin
          door_nx = 1'b1;
          if (sos && !cur_bit[0]) begin
            state_nx = IDLE;
            door_nx  = 1'b0;
          end else if (!sos && |(pending & cur_bit)) begin
            clear_nx = cur_bit;
            dwell_nx = DWELL_LOAD;
          end else if (weight_over || sos) begin
            dwell_nx = DWELL_LOAD;
          end else if (dwell == '0) begin
            state_nx = IDLE;
            door_nx  = 1'b0;
          end else begin
            dwell_nx = dwell - DWELL_W'(1);
          end
        end
        default: begin
          state_nx = IDLE;
          valid_nx = 1'b0;
          door_nx  = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trip_scheduler.sv
// Bench for trip_scheduler: directed scenarios plus random call batches scored
// against a SCAN service-order model; a negedge monitor drains the expectations.
`timescale 1ns/1ps
module tb_trip_scheduler;
  import trip_scheduler_pkg::*;

  localparam int MOVE_CYC = 3;

  typedef struct {
    int floor;
    bit dir;
  } goal_t;

  logic        door_clk = 1'b0;
  logic        button_reset = 1'b0;
  call_vec_t   call_req = '0;
  logic [1:0]  cur_floor = 2'b00;
  logic        weight_over = 1'b0;
  logic        sos_mode = 1'b0;
  logic [1:0]  goal_floor;
  logic        goal_valid;
  call_vec_t   call_clear;
  logic        door_open;
  logic        dir_up;

  int checks = 0;
  int errors = 0;

  int    exp_serve[$];
  goal_t exp_goal[$];
  bit    model_dir = 1'b1;

  call_vec_t  clr_seen = '0;
  logic       s_valid = 1'b0;
  logic [1:0] s_goal = 2'b00;
  int         move_cnt = 0;
  bit         plant_auto = 1'b0;
  bit         mon_en = 1'b0;
  logic       mon_prev_valid = 1'b0;
  int         mon_f;
  goal_t      mon_g;

  trip_scheduler dut (
    .door_clk    (door_clk),
    .button_reset(button_reset),
    .call_req    (call_req),
    .cur_floor   (cur_floor),
    .weight_over (weight_over),
    .sos_mode    (sos_mode),
    .goal_floor  (goal_floor),
    .goal_valid  (goal_valid),
    .call_clear  (call_clear),
    .door_open   (door_open),
    .dir_up      (dir_up)
  );

  always #5 door_clk = ~door_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // One clock: sample at negedge, then after the edge the call latch drops
  // acknowledged calls and the car plant steps toward the commanded goal.
  task automatic tick();
    @(negedge door_clk);
    clr_seen = call_clear;
    s_valid  = goal_valid;
    s_goal   = goal_floor;
    @(posedge door_clk);
    #1;
    call_req = call_req & ~clr_seen;
    if (plant_auto && s_valid && cur_floor != s_goal) begin
      move_cnt++;
      if (move_cnt >= MOVE_CYC) begin
        move_cnt  = 0;
        cur_floor = (s_goal > cur_floor) ? cur_floor + 2'd1 : cur_floor - 2'd1;
      end
    end else begin
      move_cnt = 0;
    end
  endtask

  task automatic do_reset();
    #3 button_reset = 1'b1;
    repeat (2) @(negedge door_clk);
    button_reset = 1'b0;
    clr_seen = '0;
    move_cnt = 0;
  endtask

  // Expected service order for a batch of calls issued to an idle car.
  task automatic model_batch(input call_vec_t calls, input int start);
    call_vec_t s;
    int pos, nxt;
    goal_t g;
    s = calls;
    pos = start;
    if (s[pos]) begin
      exp_serve.push_back(pos);
      s[pos] = 1'b0;
    end
    while (s != '0) begin
      nxt = -1;
      if (model_dir) begin
        for (int f = pos + 1; f < 3; f++) if (s[f] && nxt < 0) nxt = f;
        if (nxt < 0) begin
          model_dir = 1'b0;
          for (int f = pos - 1; f >= 0; f--) if (s[f] && nxt < 0) nxt = f;
        end
      end else begin
        for (int f = pos - 1; f >= 0; f--) if (s[f] && nxt < 0) nxt = f;
        if (nxt < 0) begin
          model_dir = 1'b1;
          for (int f = pos + 1; f < 3; f++) if (s[f] && nxt < 0) nxt = f;
        end
      end
      g.floor = nxt;
      g.dir = model_dir;
      exp_goal.push_back(g);
      exp_serve.push_back(nxt);
      s[nxt] = 1'b0;
      pos = nxt;
    end
  endtask

  always @(negedge door_clk) begin
    if (mon_en && !button_reset) begin
      if (call_clear != '0) begin
        checks++;
        if (exp_serve.size() == 0) begin
          errors++;
          $display("FAIL serve_order: call_clear=%b, required no clear", call_clear);
        end else begin
          mon_f = exp_serve.pop_front();
          if (call_clear != call_vec_t'(32'd1 << mon_f)) begin
            errors++;
            $display("FAIL serve_order: call_clear=%b, required %b", call_clear,
                     call_vec_t'(32'd1 << mon_f));
          end
        end
      end
      if (goal_valid && !mon_prev_valid) begin
        checks++;
        if (exp_goal.size() == 0) begin
          errors++;
          $display("FAIL goal_order: goal_floor=%0d dispatched, required none", goal_floor);
        end else begin
          mon_g = exp_goal.pop_front();
          if (int'(goal_floor) != mon_g.floor || dir_up != mon_g.dir) begin
            errors++;
            $display("FAIL goal_order: goal=%0d dir=%0d, required goal=%0d dir=%0d",
                     goal_floor, dir_up, mon_g.floor, mon_g.dir);
          end
        end
      end
    end
    mon_prev_valid = goal_valid;
  end

  initial begin
    int clear_cnt, door_cnt, n_rise, held_cnt, rel_cnt;
    call_vec_t clear_or, calls;
    logic prev_valid;
    bit done;
    int g_seen[2];
    int d_seen[2];

    // Asynchronous reset values, then first dispatch F1 -> F3.
    #13 button_reset = 1'b1;
    #1;
    check("reset_goal_floor", goal_floor, 0);
    check("reset_goal_valid", goal_valid, 0);
    check("reset_call_clear", call_clear, 0);
    check("reset_door_open", door_open, 0);
    check("reset_dir_up", dir_up, 1);
    repeat (2) @(negedge door_clk);
    button_reset = 1'b0;
    call_req = 3'b100;
    @(posedge door_clk);
    #1;
    check("dispatch_goal_valid", goal_valid, 1);
    check("dispatch_goal_floor", goal_floor, 2);
    check("dispatch_dir_up", dir_up, 1);

    // Reset while moving toward F3 abandons the trip immediately.
    tick();
    tick();
    check("moving_goal_frozen", goal_floor, 2);
    #3 button_reset = 1'b1;
    #1;
    check("midtrip_reset_valid", goal_valid, 0);
    check("midtrip_reset_goal", goal_floor, 0);
    check("midtrip_reset_door", door_open, 0);
    @(negedge door_clk);
    button_reset = 1'b0;
    @(posedge door_clk);
    #1;
    check("redispatch_after_reset", goal_valid, 1);

    // Arrival at F3: one clear pulse, door open for DWELL cycles.
    plant_auto = 1'b1;
    clear_cnt = 0;
    clear_or = '0;
    door_cnt = 0;
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      tick();
      if (call_clear != '0) begin
        clear_cnt++;
        clear_or |= call_clear;
      end
      if (door_open) door_cnt++;
      if (clear_cnt > 0 && !door_open && !goal_valid) done = 1'b1;
    end
    check("arrival_done", done, 1);
    check("arrival_clear_pulses", clear_cnt, 1);
    check("arrival_clear_bit", clear_or, 4);
    check("arrival_door_cycles", door_cnt, 2);
    check("arrival_floor", cur_floor, 2);

    // From F2 going up with calls at F1 and F3: F3 first, then F1 going down.
    cur_floor = FLOOR_F2;
    do_reset();
    call_req = 3'b101;
    n_rise = 0;
    prev_valid = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 150 && !done; i++) begin
      tick();
      if (goal_valid && !prev_valid) begin
        if (n_rise < 2) begin
          g_seen[n_rise] = int'(goal_floor);
          d_seen[n_rise] = int'(dir_up);
        end
        n_rise++;
      end
      prev_valid = goal_valid;
      if (n_rise > 0 && call_req == '0 && !door_open && !goal_valid) done = 1'b1;
    end
    check("scan_done", done, 1);
    check("scan_dispatches", n_rise, 2);
    if (n_rise == 2) begin
      check("scan_first_goal", g_seen[0], 2);
      check("scan_first_dir", d_seen[0], 1);
      check("scan_second_goal", g_seen[1], 0);
      check("scan_second_dir", d_seen[1], 0);
    end

    // Overload holds the door open; it closes two cycles after release.
    call_req = 3'b001;
    weight_over = 1'b1;
    held_cnt = 0;
    clear_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (door_open) held_cnt++;
      if (call_clear != '0) clear_cnt++;
    end
    check("overload_door_held", held_cnt, 5);
    check("overload_clear_pulses", clear_cnt, 1);
    weight_over = 1'b0;
    rel_cnt = 0;
    done = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      tick();
      rel_cnt++;
      if (!door_open) done = 1'b1;
    end
    check("overload_release_cycles", rel_cnt, 2);

    // Emergency request while moving to F3.
    plant_auto = 1'b0;
    call_req = 3'b100;
    tick();
    check("sos_pre_goal", goal_floor, 2);
    sos_mode = 1'b1;
    tick();
`ifdef SOS_RECALL_EN
    check("sos_goal", goal_floor, 0);
`else
    check("sos_goal", goal_floor, 2);
`endif
    check("sos_goal_valid", goal_valid, 1);
    sos_mode = 1'b0;
    call_req = '0;
    do_reset();

    // Illegal floor code keeps or returns the scheduler to IDLE.
    cur_floor = 2'b11;
    call_req = 3'b010;
    tick();
    tick();
    check("illegal_idle_valid", goal_valid, 0);
    check("illegal_idle_door", door_open, 0);
    cur_floor = FLOOR_F1;
    tick();
    check("legal_dispatch", goal_valid, 1);
    cur_floor = 2'b11;
    tick();
    check("illegal_abort_valid", goal_valid, 0);
    cur_floor = FLOOR_F1;
    call_req = '0;
    do_reset();

    // Random call batches against the service-order model.
    model_dir = 1'b1;
    plant_auto = 1'b1;
    mon_en = 1'b1;
    for (int b = 0; b < 30; b++) begin
      calls = call_vec_t'($urandom_range(1, 7));
      model_batch(calls, int'(cur_floor));
      call_req = calls;
      done = 1'b0;
      for (int t = 0; t < 400 && !done; t++) begin
        weight_over = ($urandom_range(0, 3) == 0);
        tick();
        if (call_req == '0 && !goal_valid && !door_open &&
            exp_serve.size() == 0 && exp_goal.size() == 0) done = 1'b1;
      end
      weight_over = 1'b0;
      check("batch_complete", done, 1);
      if (!done) begin
        exp_serve.delete();
        exp_goal.delete();
        call_req = '0;
        do_reset();
        model_dir = 1'b1;
      end
    end
    mon_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
